// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO fed by bus stores, baud counter and frame FSM.
// STATUS/BAUD_DIV readback is combinational on bus_addr.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 868,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic              bus_we,
  input  logic              bus_re,
  output logic [31:0]       bus_rdata,
  output logic              tx,
  output logic              tx_busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_W-1:0] AddrTxdata = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AddrBaud   = ADDR_W'(8);
  localparam logic [15:0]       DefDiv     = 16'(DEFAULT_DIV);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       baud_div_q, baud_div_d;
  logic [15:0]       bit_div_q, bit_div_d;
  logic [15:0]       baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] addr_word;
  logic              wr_txdata, wr_status, wr_baud;
  logic              fifo_full, fifo_empty, push_ok, pop, bit_end;
  logic [4:0]        count_field;
  logic              unused_bits;

  assign addr_word   = {bus_addr[ADDR_W-1:2], 2'b00};
  assign wr_txdata   = bus_we && (addr_word == AddrTxdata);
  assign wr_status   = bus_we && (addr_word == AddrStatus);
  assign wr_baud     = bus_we && (addr_word == AddrBaud);
  assign fifo_full   = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  // Full is judged on the current count, so a same-cycle pop never rescues a push.
  assign push_ok     = wr_txdata && !fifo_full;
  assign bit_end     = (baud_cnt_q == bit_div_q - 16'd1);
  assign count_field = 5'(count_q);
  assign unused_bits = ^{bus_re, bus_wdata[31:16], bus_addr[1:0]};

  // FIFO pointers, count and control registers
  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CntW'(1);
    end
    ovf_d = ovf_q;
    if (wr_txdata && fifo_full) begin
      ovf_d = 1'b1;
    end else if (wr_status && bus_wdata[3]) begin
      ovf_d = 1'b0;
    end
    baud_div_d = baud_div_q;
    if (wr_baud) begin
      baud_div_d = (bus_wdata[15:0] == 16'd0) ? 16'd1 : bus_wdata[15:0];
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= bus_wdata[7:0];
    end
  end

  // State register
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      baud_div_q <= DefDiv;
      bit_div_q  <= 16'd0;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      baud_div_q <= baud_div_d;
      bit_div_q  <= bit_div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    shift_d    = shift_q;
    bit_div_d  = bit_div_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = bit_end ? 16'd0 : baud_cnt_q + 16'd1;
    unique case (state_q)
      StIdle: begin
        baud_cnt_d = 16'd0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_mem[rd_ptr_q];
          bit_div_d = baud_div_q;
          bit_cnt_d = 3'd0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; tx lags the state by one cycle so the line is glitch-free
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle) || (count_d != '0);
  end

  always_comb begin
    bus_rdata = 32'd0;
    case (addr_word)
      AddrStatus: bus_rdata = {23'd0, count_field, ovf_q, busy_q, fifo_empty, fifo_full};
      AddrBaud:   bus_rdata = {16'd0, baud_div_q};
      default:    bus_rdata = 32'd0;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the data-store path of RISC_V_Base_data_path.
- The datapath's load/store unit writes bytes into a small TX FIFO.
- A baud-rate counter and frame FSM serialise each byte onto a 1-bit tx line (8N1, LSB first).
- Software polls the STATUS register; the same bus provides readback.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.
- DEFAULT_DIV, 868, reset value of BAUD_DIV in clocks per bit (100 MHz / 115200).
- ADDR_W, 4, width of the byte-offset address into the register window.

Ports:
- cpu_clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_addr  in  ADDR_W  byte offset within the window; bits [1:0] ignored.
- bus_wdata  in  32  store data.
- bus_we  in  1  store strobe, one cycle per store.
- bus_re  in  1  load strobe; qualifies read side effects only.
- bus_rdata  out  32  combinational read data for the current bus_addr.
- tx  out  1  serial output, idle high.
- tx_busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Register map:
  - 0x0 TXDATA: write pushes bus_wdata[7:0]; reads 0.
  - 0x4 STATUS: read returns [0] full, [1] empty, [2] busy, [3] overflow, [8:4] fifo count, other bits 0. A write with bus_wdata[3]=1 clears overflow.
  - 0x8 BAUD_DIV: R/W [15:0]; a written value of 0 is stored as 1.
  - Other offsets: read 0, writes ignored.
- Reset (reset=0, asynchronous): tx=1, tx_busy=0, FIFO empty (count 0), overflow=0, BAUD_DIV=DEFAULT_DIV, FSM=IDLE, counters 0. Asserting reset mid-frame drives tx high immediately; the in-flight byte and all queued bytes are lost.
- FIFO: circular buffer with read/write pointers and a count.
  - A push is accepted when count<FIFO_DEPTH.
  - A push while full is dropped and sets overflow (sticky). This holds even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle keep count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if count>0, pop the head into shift_reg, latch BAUD_DIV into bit_div, go to START, clear bit_cnt and baud_cnt.
  - START: tx=0 for bit_div cycles, then go to DATA.
  - DATA: tx=shift_reg[0]; after bit_div cycles, shift right. Advance through 8 bits (bit_cnt 0..7), then go to STOP.
  - STOP: tx=1 for bit_div cycles, then go to IDLE. If the FIFO is non-empty at that point, the next pop happens on the IDLE cycle, giving one extra idle-high cycle between frames.
- tx is a registered output, a function of the state and shift register.
- Frame length: 10*bit_div + 1 cycles between back-to-back start edges.
- Baud timing: baud_cnt counts 0..bit_div-1; the bit ends when baud_cnt==bit_div-1. A BAUD_DIV write mid-frame affects only the next frame.
- Latency: a TXDATA store at edge N with the FIFO empty and FSM IDLE gives count=1 after N, pop at N+1, and tx low after edge N+2.
- tx_busy: registered from the next-state values. It falls in the cycle after the final stop bit completes with the FIFO empty.
- bus_re has no side effects; it is reserved for future read-clear registers.

Test Plan:
- Reset: hold reset=0 for 3 cycles → tx=1, STATUS reads 0x00000002 (empty), BAUD_DIV reads 868; assert reset=0 mid-frame → tx=1 within the same cycle.
- Single byte: BAUD_DIV=4, write 0x55 → tx low 2 edges after the store; bits 0,1,0,1,0,1,0,1,0,1 at 4 cycles each (start, data LSB first, stop); tx_busy deasserts after 40 cycles of frame.
- Back-to-back: BAUD_DIV=2, write 0xA5, 0x3C, 0xFF on consecutive cycles → STATUS count reads 2 after the first pop; three frames 21 cycles apart; decoded bytes A5, 3C, FF.
- Overflow: BAUD_DIV=100, write 10 bytes 0x00..0x09 consecutively → first popped, 8 queued, 10th dropped; STATUS reads full=1, overflow=1, count=8; write STATUS 0x8 → overflow=0; transmitted stream is 0x00..0x08.
- Divisor edge: write BAUD_DIV=0 → reads 1; byte 0x80 sent with 1-cycle bits. Change BAUD_DIV to 8 mid-frame → current frame keeps 1-cycle bits, next frame uses 8.
- Unmapped: write 0xC with 0xFFFFFFFF → no FIFO change; read 0xC → 0.
